fifo_ctrl_v2: RTL

- Parametrised single-clock FIFO, the next generation of the team's single-clock FIFO.
- Adds selectable showahead/normal read mode, threshold flags, a synchronous flush, and sticky overflow/underflow error flags.
- Sits between streaming producers and consumers in the datapath.
- Storage is an internal array of 2**AWIDTH words. No external RAM wrapper.

---
 rtl/fifo_ctrl_v2.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/fifo_ctrl_v2.sv
// fifo_ctrl_v2 -- parametrised single-clock FIFO controller with internal storage.
//
// Features:
//   - 2**AWIDTH words of DWIDTH bits held in an internal register array.
//   - Showahead (SHOWAHEAD=1) or registered-read (SHOWAHEAD=0) output mode.
//   - Occupancy count plus full/empty/almost_full/almost_empty flags.
//   - Synchronous flush and sticky overflow/underflow error flags.
//
// Optional feature, enabled by defining the macro FIFO_CTRL_V2_PEAK_EN:
//   - Adds peak_usedw_o, the high-water mark of usedw_o since reset or since
//     the last err_clr_i pulse. Without the macro the port and its logic are
//     absent and everything else behaves identically.
//
// Reset: arst_n_i asserts asynchronously. Its release is synchronised to
// clk_i by a two-flop synchroniser before it reaches the state registers.

module fifo_ctrl_v2 #(
  parameter int DWIDTH             = 64,
  parameter int AWIDTH             = 4,
  parameter int SHOWAHEAD          = 1,
  parameter int ALMOST_FULL_VALUE  = 12,
  parameter int ALMOST_EMPTY_VALUE = 2
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              flush_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              wrreq_i,
  input  logic              rdreq_i,
  input  logic              err_clr_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic              overflow_o,
`ifdef FIFO_CTRL_V2_PEAK_EN
  output logic              underflow_o,
  output logic [AWIDTH:0]   peak_usedw_o
`else
  output logic              underflow_o
`endif
);

  localparam int              DEPTH_C   = 2**AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_W_C = (AWIDTH+1)'(DEPTH_C);
  localparam logic [AWIDTH:0] ONE_W_C   = (AWIDTH+1)'(1'b1);
  localparam logic [AWIDTH:0] ZERO_W_C  = (AWIDTH+1)'(1'b0);
  localparam logic [AWIDTH-1:0] ONE_P_C  = AWIDTH'(1'b1);
  localparam logic [AWIDTH-1:0] ZERO_P_C = AWIDTH'(1'b0);
  localparam logic [DWIDTH-1:0] ZERO_D_C = DWIDTH'(1'b0);

  // Reset synchroniser and internal reset
  logic [1:0] rst_sync_r;
  logic       rst_n_s;

  // Storage and state registers
  logic [DWIDTH-1:0] mem_r [DEPTH_C];
  logic [AWIDTH-1:0] wr_ptr_r;
  logic [AWIDTH-1:0] rd_ptr_r;
  logic [AWIDTH:0]   usedw_r;
  logic [DWIDTH-1:0] q_r;
  logic              overflow_r;
  logic              underflow_r;

  // Combinational next-state and control
  logic              full_s;
  logic              empty_s;
  logic              wr_acc_s;
  logic              rd_acc_s;
  logic              ovf_set_s;
  logic              unf_set_s;
  logic [AWIDTH-1:0] wr_ptr_nxt_s;
  logic [AWIDTH-1:0] rd_ptr_nxt_s;
  logic [AWIDTH:0]   usedw_nxt_s;
  logic [DWIDTH-1:0] head_nxt_s;
  logic [DWIDTH-1:0] q_nxt_s;
  int                usedw_int_s;

  // Async-assert, sync-release reset synchroniser
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

  // Status flags come straight from the registered occupancy count
  assign full_s      = (usedw_r == DEPTH_W_C);
  assign empty_s     = (usedw_r == ZERO_W_C);
  assign usedw_int_s = int'(usedw_r);

  // Accepts are qualified by the registered flags; flush suppresses both
  assign wr_acc_s  = wrreq_i & ~full_s  & ~flush_i;
  assign rd_acc_s  = rdreq_i & ~empty_s & ~flush_i;
  assign ovf_set_s = wrreq_i &  full_s  & ~flush_i;
  assign unf_set_s = rdreq_i &  empty_s & ~flush_i;

  // Next pointer and occupancy values; flush overrides any accepted traffic
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    usedw_nxt_s  = usedw_r;
    if (flush_i) begin
      wr_ptr_nxt_s = ZERO_P_C;
      rd_ptr_nxt_s = ZERO_P_C;
      usedw_nxt_s  = ZERO_W_C;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_nxt_s = wr_ptr_r + ONE_P_C;
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (rd_acc_s) begin
        rd_ptr_nxt_s = rd_ptr_r + ONE_P_C;
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   usedw_nxt_s = usedw_r + ONE_W_C;
        2'b01:   usedw_nxt_s = usedw_r - ONE_W_C;
        default: usedw_nxt_s = usedw_r;
      endcase
    end
  end

  // Word that will be at the head after this edge; when the head slot is the
  // one being written right now, the array does not hold it yet, so bypass
  always_comb begin
    head_nxt_s = mem_r[rd_ptr_nxt_s];
    if (wr_acc_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
      head_nxt_s = data_i;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Output data selection for the two read modes; flush leaves q_o alone
  always_comb begin
    q_nxt_s = q_r;
    if (flush_i) begin
      q_nxt_s = q_r;
    end else if (SHOWAHEAD != 0) begin
      if (usedw_nxt_s != ZERO_W_C) begin
        q_nxt_s = head_nxt_s;
      end else begin
        q_nxt_s = q_r;
      end
    end else begin
      if (rd_acc_s) begin
        q_nxt_s = mem_r[rd_ptr_r];
      end else begin
        q_nxt_s = q_r;
      end
    end
  end

  // Storage array write port; contents are never reset, pointers define validity
  always_ff @(posedge clk_i) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= data_i;
    end
  end

  // Pointer, occupancy and read-data registers
  always_ff @(posedge clk_i or negedge rst_n_s) begin
    if (!rst_n_s) begin
      wr_ptr_r <= ZERO_P_C;
      rd_ptr_r <= ZERO_P_C;
      usedw_r  <= ZERO_W_C;
      q_r      <= ZERO_D_C;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      usedw_r  <= usedw_nxt_s;
      q_r      <= q_nxt_s;
    end
  end

  // Sticky error flags; a new error event wins over a simultaneous clear
  always_ff @(posedge clk_i or negedge rst_n_s) begin
    if (!rst_n_s) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (err_clr_i) begin
        overflow_r <= 1'b0;
      end
      if (unf_set_s) begin
        underflow_r <= 1'b1;
      end else if (err_clr_i) begin
        underflow_r <= 1'b0;
      end
    end
  end

`ifdef FIFO_CTRL_V2_PEAK_EN
  logic [AWIDTH:0] peak_r;

  // High-water mark, trailing usedw by one cycle; err_clr_i restarts it
  always_ff @(posedge clk_i or negedge rst_n_s) begin
    if (!rst_n_s) begin
      peak_r <= ZERO_W_C;
    end else if (err_clr_i) begin
      peak_r <= usedw_r;
    end else if (usedw_r > peak_r) begin
      peak_r <= usedw_r;
    end
  end

  assign peak_usedw_o = peak_r;
`endif

  assign q_o            = q_r;
  assign usedw_o        = usedw_r;
  assign empty_o        = empty_s;
  assign full_o         = full_s;
  assign almost_full_o  = (usedw_int_s >= ALMOST_FULL_VALUE);
  assign almost_empty_o = (usedw_int_s <  ALMOST_EMPTY_VALUE);
  assign overflow_o     = overflow_r;
  assign underflow_o    = underflow_r;

endmodule
